hazard_ctrl_unit: RTL and testbench

Parametrised forwarding/hazard controller for the 3-stage (IF / DE / MW) RISC-V pipeline, sitting between the DE and MW pipeline registers and driving the operand forwarding muxes, stage stall enables and the pipeline flush. Extends operand-hazard detection to all rs1/rs2 consumers (R, I-ALU, load, store, branch, JALR). Adds a multi-cycle load-use stall sequencer for synchronous data memory, multi-cycle flush sequencing for branch/interrupt/mret, and saturating stall/flush event counters.

---
 rtl/hazard_ctrl_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Operand forwarding, load-use stall sequencing and flush sequencing for the 3-stage IF/DE/MW pipeline.
// Latency: all outputs combinational from state and current inputs; counters update on the next edge.
// Backpressure: stall/stall_mw hold the front end and MW while a load completes; flush squashes IF/DE.
module hazard_ctrl_unit #(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int EXT_FWD      = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_de,
    input  logic [31:0]      inst_mw,
    input  logic             reg_wr_mw,
    input  logic             br_taken,
    input  logic             is_mret,
    input  logic [1:0]       interrupt,
    output logic             for_a,
    output logic             for_b,
    output logic             stall,
    output logic             stall_mw,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam bit         EXT   = (EXT_FWD != 0);
    localparam logic [7:0] LL_M1 = 8'(LOAD_LAT - 1);
    localparam logic [7:0] FL_M1 = 8'(FLUSH_CYCLES - 1);

    typedef struct packed {
        logic [6:0] op_de;
        logic [6:0] op_mw;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } hdr_t;

    typedef enum logic [1:0] {IDLE, LSTALL, RELEASE, FLUSH} state_t;

    hdr_t       hdr;
    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       rs1_user, rs2_user, hit_a, hit_b, lu, fe;

    assign hdr = '{op_de: inst_de[6:0], op_mw: inst_mw[6:0], rs1: inst_de[19:15],
                   rs2: inst_de[24:20], rd: inst_mw[11:7]};

    always_comb begin
        rs1_user = (hdr.op_de == OP_R) || (hdr.op_de == OP_I) ||
                   (EXT && ((hdr.op_de == OP_LD) || (hdr.op_de == OP_ST) ||
                            (hdr.op_de == OP_BR) || (hdr.op_de == OP_JALR)));
        rs2_user = (hdr.op_de == OP_R) ||
                   (EXT && ((hdr.op_de == OP_ST) || (hdr.op_de == OP_BR)));
    end

    // x0 is hardwired to zero, so a write to it never produces a forwardable value
    assign hit_a = reg_wr_mw && rs1_user && (hdr.rs1 != 5'd0) && (hdr.rs1 == hdr.rd);
    assign hit_b = reg_wr_mw && rs2_user && (hdr.rs2 != 5'd0) && (hdr.rs2 == hdr.rd);
    assign lu    = (hit_a || hit_b) && (hdr.op_mw == OP_LD) && (LOAD_LAT > 0);
    assign fe    = br_taken || is_mret || (interrupt == 2'b01);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        for_a     = 1'b0;
        for_b     = 1'b0;
        stall     = 1'b0;
        stall_mw  = 1'b0;
        flush     = 1'b0;
        if (rst) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
        end else if (fe) begin
            // a new event always restarts the flush window, even mid-stall or mid-flush
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = FL_M1;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (lu) begin
                        stall    = 1'b1;
                        stall_mw = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt = LSTALL;
                            cnt_nxt   = LL_M1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end else begin
                        for_a = hit_a;
                        for_b = hit_b;
                    end
                end
                LSTALL: begin
                    stall    = 1'b1;
                    stall_mw = 1'b1;
                    cnt_nxt  = cnt - 8'd1;
                    if (cnt == 8'd1) state_nxt = RELEASE;
                end
                RELEASE: begin
                    // load data is now available; forward it rather than re-detecting the hazard
                    for_a     = hit_a;
                    for_b     = hit_b;
                    state_nxt = IDLE;
                end
                FLUSH: begin
                    flush   = 1'b1;
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two parameterisations driven in parallel, checked by table, hand sequences
// and a cycle-count reference model under random stimulus.
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_de, inst_mw;
    logic        reg_wr_mw, br_taken, is_mret;
    logic [1:0]  interrupt;

    logic        fa0, fb0, st0, smw0, fl0;
    logic [15:0] sc0, fc0;
    logic        fa1, fb1, st1, smw1, fl1;
    logic [2:0]  sc1, fc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.LOAD_LAT(2), .FLUSH_CYCLES(3), .EXT_FWD(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .inst_de(inst_de), .inst_mw(inst_mw), .reg_wr_mw(reg_wr_mw),
        .br_taken(br_taken), .is_mret(is_mret), .interrupt(interrupt),
        .for_a(fa0), .for_b(fb0), .stall(st0), .stall_mw(smw0), .flush(fl0),
        .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_ctrl_unit #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .EXT_FWD(0), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .inst_de(inst_de), .inst_mw(inst_mw), .reg_wr_mw(reg_wr_mw),
        .br_taken(br_taken), .is_mret(is_mret), .interrupt(interrupt),
        .for_a(fa1), .for_b(fb1), .stall(st1), .stall_mw(smw1), .flush(fl1),
        .stall_cnt(sc1), .flush_cnt(fc1));

    typedef struct packed {
        logic        fa;
        logic        fb;
        logic        st;
        logic        smw;
        logic        fl;
        logic [15:0] sc;
        logic [15:0] fc;
    } obs_t;

    // Model state: how many more cycles of flush / stall are owed, and whether a release cycle is due
    typedef struct {
        int flush_left;
        int stall_left;
        bit release_due;
        int scnt;
        int fcnt;
    } ms_t;

    typedef struct {
        logic [31:0] de;
        logic [31:0] mw;
        logic        wr;
        logic [1:0]  intr;
        logic [3:0]  e0;
        logic [3:0]  e1;
    } vec_t;

    ms_t  ms[2];
    obs_t act[2];

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] ADD_X5  = 32'h002082B3;
    localparam logic [31:0] SUB_X6  = 32'h40328333;
    localparam logic [31:0] LW_X5   = 32'h0000A283;

    function automatic int p_ll(input int k);  return (k == 0) ? 2 : 1; endfunction
    function automatic int p_fc(input int k);  return (k == 0) ? 3 : 1; endfunction
    function automatic bit p_ext(input int k); return (k == 0); endfunction
    function automatic int p_max(input int k); return (k == 0) ? 65535 : 7; endfunction

    function automatic logic [1:0] hits(input bit ext, input logic [31:0] de, input logic [31:0] mw,
                                        input logic wr);
        logic [6:0] op;
        bit         u1, u2, ha, hb;
        op = de[6:0];
        u1 = (op == 7'b0110011) || (op == 7'b0010011) ||
             (ext && (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011 || op == 7'b1100111));
        u2 = (op == 7'b0110011) || (ext && (op == 7'b0100011 || op == 7'b1100011));
        ha = wr && u1 && de[19:15] != 5'd0 && de[19:15] == mw[11:7];
        hb = wr && u2 && de[24:20] != 5'd0 && de[24:20] == mw[11:7];
        return {ha, hb};
    endfunction

    task automatic model_eval(input int k, output obs_t e, output ms_t n);
        ms_t        s;
        logic [1:0] h;
        bit         fe, lu;
        s  = ms[k];
        n  = s;
        e  = '0;
        e.sc = 16'(s.scnt);
        e.fc = 16'(s.fcnt);
        h  = hits(p_ext(k), inst_de, inst_mw, reg_wr_mw);
        fe = br_taken || is_mret || interrupt == 2'b01;
        lu = (h != 2'b00) && inst_mw[6:0] == 7'b0000011 && p_ll(k) > 0;
        if (rst) begin
            n = '{0, 0, 1'b0, 0, 0};
        end else begin
            if (fe) begin
                e.fl = 1'b1;
                n.flush_left = p_fc(k) - 1;
                n.stall_left = 0;
                n.release_due = 1'b0;
            end else if (s.flush_left > 0) begin
                e.fl = 1'b1;
                n.flush_left = s.flush_left - 1;
            end else if (s.stall_left > 0) begin
                e.st = 1'b1;
                n.stall_left = s.stall_left - 1;
                n.release_due = (n.stall_left == 0);
            end else if (s.release_due) begin
                {e.fa, e.fb} = h;
                n.release_due = 1'b0;
            end else if (lu) begin
                e.st = 1'b1;
                n.stall_left = p_ll(k) - 1;
                n.release_due = (p_ll(k) == 1);
            end else begin
                {e.fa, e.fb} = h;
            end
            e.smw = e.st;
            if (e.st && s.scnt < p_max(k)) n.scnt = s.scnt + 1;
            if (e.fl && s.fcnt < p_max(k)) n.fcnt = s.fcnt + 1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Inputs are driven just after a rising edge; outputs sampled on the falling edge.
    task automatic cycle(input string tag);
        obs_t e[2];
        ms_t  n[2];
        #4;
        act[0] = '{fa0, fb0, st0, smw0, fl0, sc0, fc0};
        act[1] = '{fa1, fb1, st1, smw1, fl1, 16'(sc1), 16'(fc1)};
        for (int k = 0; k < 2; k++) begin
            model_eval(k, e[k], n[k]);
            chk($sformatf("%s/model%0d", tag, k), 64'(act[k]), 64'(e[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) ms[k] = n[k];
        #1;
    endtask

    task automatic set_in(input logic [31:0] de, input logic [31:0] mw, input logic wr);
        inst_de = de; inst_mw = mw; reg_wr_mw = wr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle("reset");
        chk("reset_bits", 64'({act[0].fa, act[0].fb, act[0].st, act[0].smw, act[0].fl}), 64'd0);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b1100111;
            6: w[6:0] = 7'b0110111;
            default: w[6:0] = 7'b1101111;
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    vec_t tbl[13];

    initial begin
        // {de, mw, wr, intr, {fa,fb,stall,flush} for u0, same for u1}
        tbl[0]  = '{SUB_X6,       ADD_X5,       1'b1, 2'b00, 4'b1000, 4'b1000};
        tbl[1]  = '{32'h005283B3, ADD_X5,       1'b1, 2'b00, 4'b1100, 4'b1100};
        tbl[2]  = '{32'h00128313, ADD_X5,       1'b1, 2'b00, 4'b1000, 4'b1000};
        tbl[3]  = '{32'h0052A023, ADD_X5,       1'b1, 2'b00, 4'b1100, 4'b0000};
        tbl[4]  = '{32'h00128063, ADD_X5,       1'b1, 2'b00, 4'b1000, 4'b0000};
        tbl[5]  = '{32'h000280E7, ADD_X5,       1'b1, 2'b00, 4'b1000, 4'b0000};
        tbl[6]  = '{32'h0002A303, ADD_X5,       1'b1, 2'b00, 4'b1000, 4'b0000};
        tbl[7]  = '{SUB_X6,       ADD_X5,       1'b0, 2'b00, 4'b0000, 4'b0000};
        tbl[8]  = '{32'h00000333, 32'h00208033, 1'b1, 2'b00, 4'b0000, 4'b0000};
        tbl[9]  = '{SUB_X6,       32'h00208033, 1'b1, 2'b00, 4'b0000, 4'b0000};
        tbl[10] = '{32'h00028337, ADD_X5,       1'b1, 2'b00, 4'b0000, 4'b0000};
        tbl[11] = '{SUB_X6,       ADD_X5,       1'b1, 2'b10, 4'b1000, 4'b1000};
        tbl[12] = '{32'h40518333, ADD_X5,       1'b1, 2'b00, 4'b0100, 4'b0100};

        for (int k = 0; k < 2; k++) ms[k] = '{0, 0, 1'b0, 0, 0};
        rst = 1'b1; br_taken = 1'b0; is_mret = 1'b0; interrupt = 2'b00;
        set_in(NOP, NOP, 1'b0);
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_cnts", 64'({act[0].sc, act[0].fc}), 64'd0);

        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].de, tbl[i].mw, tbl[i].wr);
            interrupt = tbl[i].intr;
            cycle("vec");
            chk($sformatf("vec%0d_u0", i), 64'({act[0].fa, act[0].fb, act[0].st, act[0].fl}), 64'(tbl[i].e0));
            chk($sformatf("vec%0d_u1", i), 64'({act[1].fa, act[1].fb, act[1].st, act[1].fl}), 64'(tbl[i].e1));
        end
        interrupt = 2'b00;

        // load-use: two stall cycles then forwarding release
        do_reset();
        set_in(SUB_X6, LW_X5, 1'b1);
        cycle("lu1");
        chk("lu1_stall", 64'({act[0].st, act[0].smw, act[0].fa, act[0].fb}), 64'b1100);
        cycle("lu2");
        chk("lu2_stall", 64'({act[0].st, act[0].smw}), 64'b11);
        cycle("lu3");
        chk("lu3_release", 64'({act[0].st, act[0].smw, act[0].fa}), 64'b001);
        set_in(NOP, NOP, 1'b0);
        cycle("lu4");
        chk("lu_stall_cnt", 64'(act[0].sc), 64'd2);

        // single flush event, then overlapping branch + mret
        do_reset();
        br_taken = 1'b1;
        cycle("fl1"); chk("fl1", 64'(act[0].fl), 64'd1);
        br_taken = 1'b0;
        cycle("fl2"); chk("fl2", 64'(act[0].fl), 64'd1);
        cycle("fl3"); chk("fl3", 64'(act[0].fl), 64'd1);
        cycle("fl4"); chk("fl4_end", 64'(act[0].fl), 64'd0);
        do_reset();
        br_taken = 1'b1;
        cycle("ov1");
        br_taken = 1'b0; is_mret = 1'b1;
        cycle("ov2"); chk("ov2", 64'(act[0].fl), 64'd1);
        is_mret = 1'b0;
        cycle("ov3"); chk("ov3", 64'(act[0].fl), 64'd1);
        cycle("ov4"); chk("ov4", 64'(act[0].fl), 64'd1);
        interrupt = 2'b10;
        cycle("ov5");
        chk("ov5_end", 64'(act[0].fl), 64'd0);
        chk("ov_flush_cnt", 64'(act[0].fc), 64'd4);
        interrupt = 2'b00;

        // interrupt aborts an in-flight load stall, then reset aborts the flush
        do_reset();
        set_in(SUB_X6, LW_X5, 1'b1);
        cycle("ab1");
        interrupt = 2'b01;
        cycle("ab2");
        chk("ab2_abort", 64'({act[0].st, act[0].smw, act[0].fl}), 64'b001);
        interrupt = 2'b00;
        cycle("ab3");
        chk("ab3_flush", 64'({act[0].st, act[0].fl}), 64'b01);
        rst = 1'b1;
        cycle("ab4");
        chk("ab4_rst", 64'({act[0].fa, act[0].fb, act[0].st, act[0].smw, act[0].fl}), 64'd0);
        rst = 1'b0;
        set_in(NOP, NOP, 1'b0);
        cycle("ab5");
        chk("ab5_idle", 64'(act[0]), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            set_in(rnd_inst(), rnd_inst(), 1'($urandom_range(0, 3) != 0));
            br_taken  = ($urandom_range(0, 15) == 0);
            is_mret   = ($urandom_range(0, 31) == 0);
            interrupt = ($urandom_range(0, 19) == 0) ? 2'b01 : 2'($urandom_range(0, 3) & 2'b10);
            rst       = ($urandom_range(0, 299) == 0);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
